// File: rtl/writeback_regfile_if.sv
// Writeback stage bus: the two writeback producers, the read ports, the
// hazard flag, the commit trace and the conflict counter.
interface writeback_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              mem_wb;
  logic [4:0]        mem_dst;
  logic [DATA_W-1:0] mem_data;
  logic              alu_wb;
  logic [4:0]        alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rd_hazard;
  logic              commit_valid;
  logic [4:0]        commit_dst;
  logic [DATA_W-1:0] commit_data;
  logic [CNT_W-1:0]  conflict_cnt;

  // Upstream side: producers and readers
  modport master (
    output mem_wb, mem_dst, mem_data, alu_wb, alu_dst, alu_data,
           rs1_addr, rs2_addr,
    input  alu_stall, rs1_data, rs2_data, rd_hazard,
           commit_valid, commit_dst, commit_data, conflict_cnt
  );

  // Register-file side
  modport slave (
    input  mem_wb, mem_dst, mem_data, alu_wb, alu_dst, alu_data,
           rs1_addr, rs2_addr,
    output alu_stall, rs1_data, rs2_data, rd_hazard,
           commit_valid, commit_dst, commit_data, conflict_cnt
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: 32-entry register file with one write port shared by the
// memory stage (highest priority) and the ALU bypass path. ALU results that
// lose arbitration wait in a small in-order FIFO; a full FIFO stalls the ALU.
module writeback_regfile #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  writeback_regfile_if.slave     bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0][DATA_W-1:0]         regs_q;
  logic [FIFO_DEPTH-1:0][4:0]      fdst_q;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] fdata_q;
  logic [PTR_W-1:0]                rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]                  count_q, count_d;
  logic                            cv_q;
  logic [4:0]                      cdst_q;
  logic [DATA_W-1:0]               cdata_q;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic              stall, mem_req, alu_req, fifo_ne;
  logic              we, pop, push, conflict;
  logic [4:0]        wdst;
  logic [DATA_W-1:0] wdata;
  logic              hz;
  logic [PTR_W-1:0]  off;

  // Write-port arbitration: mem, then FIFO head, then direct ALU write
  always_comb begin
    stall    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    mem_req  = bus.mem_wb & (bus.mem_dst != 5'd0);
    alu_req  = bus.alu_wb & (bus.alu_dst != 5'd0) & ~stall;
    fifo_ne  = (count_q != '0);
    conflict = mem_req & alu_req;
    we       = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    wdst     = 5'd0;
    wdata    = '0;
    if (mem_req) begin
      we    = 1'b1;
      wdst  = bus.mem_dst;
      wdata = bus.mem_data;
      push  = alu_req;
    end else if (fifo_ne) begin
      we    = 1'b1;
      wdst  = fdst_q[rd_ptr_q];
      wdata = fdata_q[rd_ptr_q];
      pop   = 1'b1;
      push  = alu_req;
    end else if (alu_req) begin
      we    = 1'b1;
      wdst  = bus.alu_dst;
      wdata = bus.alu_data;
    end
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    cnt_d   = (conflict && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  // RAW hazard against every live FIFO entry (live = within count of head)
  always_comb begin
    hz  = 1'b0;
    off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) &&
          (((bus.rs1_addr != 5'd0) && (bus.rs1_addr == fdst_q[i])) ||
           ((bus.rs2_addr != 5'd0) && (bus.rs2_addr == fdst_q[i]))))
        hz = 1'b1;
    end
  end

  // Read ports with same-cycle write bypass; r0 hardwired to zero
  assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? '0 :
                        (we && (wdst == bus.rs1_addr)) ? wdata : regs_q[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? '0 :
                        (we && (wdst == bus.rs2_addr)) ? wdata : regs_q[bus.rs2_addr];
  assign bus.rd_hazard    = hz;
  assign bus.alu_stall    = stall;
  assign bus.commit_valid = cv_q;
  assign bus.commit_dst   = cdst_q;
  assign bus.commit_data  = cdata_q;
  assign bus.conflict_cnt = cnt_q;

  // Register file, FIFO, commit trace and conflict counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '0;
      fdst_q   <= '0;
      fdata_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cv_q     <= 1'b0;
      cdst_q   <= 5'd0;
      cdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (we) regs_q[wdst] <= wdata;
      if (push) begin
        fdst_q[wr_ptr_q]  <= bus.alu_dst;
        fdata_q[wr_ptr_q] <= bus.alu_data;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      cv_q    <= we;
      if (we) begin
        cdst_q  <= wdst;
        cdata_q <= wdata;
      end
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios then random traffic, all
// checked each cycle against a queue-based model of the writeback rules.
module tb_writeback_regfile;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_regfile_if #(.DATA_W(DW), .CNT_W(CW)) bus();

  writeback_regfile #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural registers, pending ALU results in order
  typedef struct { logic [4:0] dst; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] mregs [32];
  bit          m_cv;
  logic [4:0]  m_cd;
  logic [31:0] m_cdat;
  int          m_cnt;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    m_cv = 0; m_cd = '0; m_cdat = '0; m_cnt = 0;
  endtask

  function automatic logic [31:0] rd_exp(logic [4:0] a, bit we, logic [4:0] wd, logic [31:0] wv);
    if (a == 0) return '0;
    if (we && a == wd) return wv;
    return mregs[a];
  endfunction

  // Drive inputs (just after an edge) and let them settle
  task automatic drv(input bit mwb, input logic [4:0] md, input logic [31:0] mv,
                     input bit awb, input logic [4:0] ad, input logic [31:0] av,
                     input logic [4:0] r1, input logic [4:0] r2);
    bus.mem_wb = mwb; bus.mem_dst = md; bus.mem_data = mv;
    bus.alu_wb = awb; bus.alu_dst = ad; bus.alu_data = av;
    bus.rs1_addr = r1; bus.rs2_addr = r2;
    #2;
  endtask

  // Check all outputs against the model, advance the model, cross the edge
  task automatic step();
    bit stall, mreq, areq, we, direct, hz;
    logic [4:0]  wd;
    logic [31:0] wv;
    stall  = (mq.size() == DEPTH);
    mreq   = bus.mem_wb && (bus.mem_dst != 0);
    areq   = bus.alu_wb && (bus.alu_dst != 0) && !stall;
    we = 0; direct = 0; hz = 0; wd = '0; wv = '0;
    if (mreq) begin
      we = 1; wd = bus.mem_dst; wv = bus.mem_data;
    end else if (mq.size() > 0) begin
      we = 1; wd = mq[0].dst; wv = mq[0].data;
    end else if (areq) begin
      we = 1; wd = bus.alu_dst; wv = bus.alu_data; direct = 1;
    end
    foreach (mq[i])
      if ((bus.rs1_addr != 0 && bus.rs1_addr == mq[i].dst) ||
          (bus.rs2_addr != 0 && bus.rs2_addr == mq[i].dst)) hz = 1;
    chk("stall", 32'(bus.alu_stall), 32'(stall));
    chk("rs1",   bus.rs1_data, rd_exp(bus.rs1_addr, we, wd, wv));
    chk("rs2",   bus.rs2_data, rd_exp(bus.rs2_addr, we, wd, wv));
    chk("hazard", 32'(bus.rd_hazard), 32'(hz));
    chk("cvalid", 32'(bus.commit_valid), 32'(m_cv));
    if (m_cv) begin
      chk("cdst",  32'(bus.commit_dst), 32'(m_cd));
      chk("cdata", bus.commit_data, m_cdat);
    end
    chk("conflict", 32'(bus.conflict_cnt), 32'(m_cnt));
    if (mreq) mregs[bus.mem_dst] = bus.mem_data;
    else if (mq.size() > 0) begin
      mregs[mq[0].dst] = mq[0].data;
      void'(mq.pop_front());
    end else if (areq) mregs[bus.alu_dst] = bus.alu_data;
    if (areq && !direct) mq.push_back('{bus.alu_dst, bus.alu_data});
    m_cv = we;
    if (we) begin m_cd = wd; m_cdat = wv; end
    if (mreq && areq && m_cnt < MAXC) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  bit          h_awb;
  logic [4:0]  h_adst;
  logic [31:0] h_adata;

  initial begin
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("rst_stall", 32'(bus.alu_stall), 0);
    chk("rst_cv",    32'(bus.commit_valid), 0);
    chk("rst_cdst",  32'(bus.commit_dst), 0);
    chk("rst_cdata", bus.commit_data, 0);
    chk("rst_cnt",   32'(bus.conflict_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // mem write visible through bypass, committed next cycle
    drv(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 0);
    chk("t1_bypass", bus.rs1_data, 32'hDEADBEEF);
    step();
    drv(0, 0, 0, 0, 0, 0, 3, 0);
    chk("t1_cv", 32'(bus.commit_valid), 1);
    chk("t1_cdst", 32'(bus.commit_dst), 3);
    step();

    // mem and alu together: alu queued, drained next cycle
    drv(1, 4, 32'h11, 1, 5, 32'h22, 4, 5);
    chk("t2_nohz", 32'(bus.rd_hazard), 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 5);
    chk("t2_hz", 32'(bus.rd_hazard), 1);
    chk("t2_r5", bus.rs2_data, 32'h22);
    chk("t2_cnt", 32'(bus.conflict_cnt), 1);
    step();

    // fill FIFO, stall, held request accepted after first pop
    drv(1, 10, 32'hA0, 1, 6, 32'h66, 6, 7); step();
    drv(1, 11, 32'hA1, 1, 7, 32'h77, 6, 7); step();
    drv(1, 12, 32'hA2, 1, 8, 32'h88, 6, 8);
    chk("t3_stall", 32'(bus.alu_stall), 1);
    step();
    drv(0, 0, 0, 1, 8, 32'h88, 6, 0); step();
    drv(0, 0, 0, 1, 8, 32'h88, 7, 0); step();
    drv(0, 0, 0, 0, 0, 0, 8, 0);
    chk("t3_r8", bus.rs1_data, 32'h88);
    step();
    drv(0, 0, 0, 0, 0, 0, 8, 0); step();

    // r0 from both producers is ignored
    drv(1, 0, 32'h55, 1, 0, 32'h66, 0, 0);
    chk("t4_r0", bus.rs1_data, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_cv", 32'(bus.commit_valid), 0);
    chk("t4_stall", 32'(bus.alu_stall), 0);
    step();

    // direct alu write with empty FIFO
    drv(0, 0, 0, 1, 12, 32'hC0FFEE, 12, 0);
    chk("t5_bypass", bus.rs1_data, 32'hC0FFEE);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 12);
    chk("t5_cdst", 32'(bus.commit_dst), 12);
    chk("t5_nohz", 32'(bus.rd_hazard), 0);
    step();

    // reset pulse with a full FIFO
    drv(1, 13, 32'hB0, 1, 9, 32'h99, 0, 0); step();
    drv(1, 14, 32'hB1, 1, 10, 32'hAA, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 9, 4);
    chk("t6_full", 32'(bus.alu_stall), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_stall", 32'(bus.alu_stall), 0);
    chk("t6_cnt", 32'(bus.conflict_cnt), 0);
    chk("t6_hz", 32'(bus.rd_hazard), 0);
    chk("t6_cv", 32'(bus.commit_valid), 0);
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      #1;
      chk("t6_reg", bus.rs1_data, 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic; producer holds alu request while stalled
    h_awb = 0; h_adst = '0; h_adata = '0;
    for (int n = 0; n < 600; n++) begin
      if (!(mq.size() == DEPTH && h_awb)) begin
        h_awb   = ($urandom_range(0, 99) < 60);
        h_adst  = 5'($urandom_range(0, 15));
        h_adata = $urandom;
      end
      drv(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 15)), $urandom,
          h_awb, h_adst, h_adata,
          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("cnt_sat", 32'(bus.conflict_cnt), MAXC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Pipeline stage directly downstream of the memory stage, holding the 32x32 architectural register file.
- Merges two writeback producers into a single register-file write port:
  - the memory stage (WB / dstout / data_out);
  - the ALU bypass path (ALU results that skip memory).
- Conflicting ALU results are buffered in a small in-order FIFO, with stall back-pressure to the ALU producer.
- Provides two combinational read ports with write bypass, a RAW-hazard flag against buffered results, and a registered commit trace.

Parameters:
- DATA_W, 32, register and data width.
- FIFO_DEPTH, 2, ALU pending-result FIFO entries (power of two, >=2).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_wb  in  1  memory-stage write request (memory stage WB output).
- mem_dst  in  5  memory-stage destination register.
- mem_data  in  DATA_W  memory-stage write data.
- alu_wb  in  1  ALU result write request.
- alu_dst  in  5  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_stall  out  1  ALU result not accepted this cycle; producer must hold alu_* unchanged.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  DATA_W  read port 1 data (combinational).
- rs2_data  out  DATA_W  read port 2 data (combinational).
- rd_hazard  out  1  rs1 or rs2 (nonzero) matches a valid FIFO entry's dst.
- commit_valid  out  1  registered: a register write occurred last cycle.
- commit_dst  out  5  registered destination of that write.
- commit_data  out  DATA_W  registered data of that write.
- conflict_cnt  out  CNT_W  saturating count of cycles with a mem write and an ALU request together.

Behaviour:
Reset (rst_n=0, asynchronous):
- All 32 registers cleared to 0; FIFO empty (count 0, pointers 0).
- alu_stall=0, commit_valid=0, commit_dst=0, commit_data=0, conflict_cnt=0.
- Reset asserted mid-operation discards all buffered FIFO entries.

Register 0:
- Always reads 0.
- Requests with dst=0 (from either producer) are treated as no request: never written, never enqueued, never committed.

Effective requests:
- mem_req = mem_wb & (mem_dst!=0).
- alu_req = alu_wb & (alu_dst!=0) & ~alu_stall.

Stall and acceptance:
- alu_stall = (count==FIFO_DEPTH), derived combinationally from registered count only.
- While alu_stall=1, alu_* inputs are ignored.

Write-port selection (exactly one write per cycle, priority order):
1. mem_req: write mem_data to mem_dst.
2. Else, FIFO not empty: pop the head and write it.
3. Else, alu_req: write alu_data directly; FIFO untouched (zero-latency path).

Enqueue:
- An alu_req not written directly in this cycle (case 1 or 2 active) is enqueued at the tail.
- Simultaneous pop and push: count unchanged.
- Order: ALU results always commit in arrival order. A mem write and a later FIFO write to the same register resolve last-writer-wins.

Read ports (combinational):
- Data = the value being written this cycle if its address equals the write-port address (write bypass); otherwise the register value.
- Address 0 returns 0.
- rd_hazard=1 if either nonzero read address equals the dst of any valid FIFO entry. An incoming, not-yet-enqueued alu request does not raise it.

Commit trace:
- Registered one cycle after each write: commit_valid=1 with that dst/data.
- commit_valid=0 on cycles with no write.

conflict_cnt:
- Increments when mem_req & alu_wb & (alu_dst!=0) & ~alu_stall.
- Saturates at all-ones, does not wrap.

FIFO pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then mem_wb=1, mem_dst=3, mem_data=0xDEADBEEF -> same cycle rs1_addr=3 reads 0xDEADBEEF via bypass; next cycle commit_valid=1, commit_dst=3.
- Single cycle with mem (dst 4, 0x11) and alu (dst 5, 0x22) -> r4 written that cycle; r5 queued (rd_hazard=1 for rs2_addr=5); r5=0x22 the next cycle; conflict_cnt=1.
- Three consecutive cycles each with mem and alu requests (alu dst 6, 7, 8) -> FIFO fills at 2 entries; alu_stall=1 on the third cycle; held dst 8 accepted after the first pop; commit order 6, 7, 8.
- Writes to r0 from both producers -> rs1_addr=0 reads 0; no commit_valid; FIFO count stays 0.
- alu_wb=1 with empty FIFO and no mem request -> written same cycle, no enqueue, alu_stall stays 0.
- FIFO holding 2 entries, rst_n pulsed low mid-cycle -> immediately count=0, alu_stall=0, all registers read 0, conflict_cnt=0.
